// File: rtl/tree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tree_pkg
// Description : Shared types for the tree-management token client: default
//               token width, token type and the request FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tree_pkg;

    // Token (node address) width used when no override is given
    localparam int DEFAULT_TOKEN_WIDTH = 8;

    typedef logic [DEFAULT_TOKEN_WIDTH-1:0] token_t;

    // Request FSM: IDLE holds tree_mgt_req_valid low, REQ holds it high
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } req_state_t;

endpackage
`default_nettype wire

// File: rtl/tree_token_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tree_token_fifo
// Description : Small synchronous FIFO with registered occupancy count.
//               push/pop must already be qualified by the caller (no push
//               while full, no pop while empty). Storage is cleared on reset
//               so head reads 0 whenever the FIFO has been reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tree_token_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    // Storage write and pointer advance; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/tree_token_client.sv
`default_nettype none
// ============================================================================
// Module      : tree_token_client
// Description : Initiator side of the tree-management token protocol.
//               Prefetches free node addresses from the space manager so the
//               insert engine gets a token with zero wait, and queues tokens
//               released by the delete engine for return to the manager.
// Revision    : 1.0 - initial release
// ============================================================================
module tree_token_client
    import tree_pkg::*;
#(
    parameter int TOKEN_WIDTH    = DEFAULT_TOKEN_WIDTH,
    parameter int PREFETCH_DEPTH = 4,
    parameter int FREE_DEPTH     = 4
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    // insert engine side
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    output logic [TOKEN_WIDTH-1:0]            alloc_token,
    // delete engine side
    input  logic                              release_valid,
    output logic                              release_ready,
    input  logic [TOKEN_WIDTH-1:0]            release_token,
    output logic [$clog2(PREFETCH_DEPTH):0]   prefetch_count,
    // space manager side
    output logic                              tree_mgt_req_valid,
    input  logic                              tree_mgt_req_ready,
    input  logic [TOKEN_WIDTH-1:0]            tree_mgt_req_addr,
    output logic                              tree_mgt_free_valid,
    input  logic                              tree_mgt_free_ready,
    output logic [TOKEN_WIDTH-1:0]            tree_mgt_free_addr,
    input  logic                              tree_mgt_full
);

    localparam int c_pf_cw  = $clog2(PREFETCH_DEPTH) + 1;
    localparam int c_rel_cw = $clog2(FREE_DEPTH) + 1;
    localparam logic [c_pf_cw-1:0] c_pf_depth = c_pf_cw'(PREFETCH_DEPTH);

    req_state_t          r_state;
    logic                r_active;

    logic                w_pf_push;
    logic                w_pf_pop;
    logic                w_pf_full;
    logic                w_pf_empty;
    logic [c_pf_cw-1:0]  w_pf_post_count;

    logic                w_rel_push;
    logic                w_rel_pop;
    logic                w_rel_full;
    logic                w_rel_empty;
    logic [c_rel_cw-1:0] w_rel_count;
    logic                w_unused;

    // ------------------------------------------------------------------
    // Prefetch path
    // ------------------------------------------------------------------
    assign w_pf_push = tree_mgt_req_valid && tree_mgt_req_ready;
    assign w_pf_pop  = alloc_valid && alloc_ready;

    // Occupancy after this edge's grant, counting a same-cycle alloc pop
    assign w_pf_post_count = prefetch_count + c_pf_cw'(1) - c_pf_cw'(w_pf_pop);

    tree_token_fifo #(
        .WIDTH (TOKEN_WIDTH),
        .DEPTH (PREFETCH_DEPTH)
    ) u_prefetch_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (w_pf_push),
        .push_data (tree_mgt_req_addr),
        .pop       (w_pf_pop),
        .head      (alloc_token),
        .full      (w_pf_full),
        .empty     (w_pf_empty),
        .count     (prefetch_count)
    );

    assign alloc_ready = !w_pf_empty;

    // Request FSM: valid is held until granted; after a grant keep asking only
    // while there is still room and the manager has tokens left
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_pf_full && !tree_mgt_full) begin
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (w_pf_push &&
                        !((w_pf_post_count < c_pf_depth) && !tree_mgt_full)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tree_mgt_req_valid = (r_state == REQ);

    // ------------------------------------------------------------------
    // Release path
    // ------------------------------------------------------------------

    // Out-of-reset flag keeps release_ready low while reset is asserted
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // Ready looks at the registered full flag only, so a full buffer refuses
    // a release even in the cycle it returns a token to the manager
    assign release_ready = r_active && !w_rel_full;
    assign w_rel_push    = release_valid && release_ready;
    assign w_rel_pop     = tree_mgt_free_valid && tree_mgt_free_ready;

    tree_token_fifo #(
        .WIDTH (TOKEN_WIDTH),
        .DEPTH (FREE_DEPTH)
    ) u_release_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (w_rel_push),
        .push_data (release_token),
        .pop       (w_rel_pop),
        .head      (tree_mgt_free_addr),
        .full      (w_rel_full),
        .empty     (w_rel_empty),
        .count     (w_rel_count)
    );

    assign tree_mgt_free_valid = !w_rel_empty;

    // Release occupancy is not needed outside the FIFO
    assign w_unused = &{1'b0, w_rel_count};

endmodule
`default_nettype wire

// File: tb/tb_tree_token_client.sv
`default_nettype none
// ============================================================================
// Module      : tb_tree_token_client
// Description : Self-checking bench for tree_token_client. A table of
//               per-cycle vectors covers the initial fill and refill, hand
//               sequences cover backpressure, manager-full, release buffering
//               and mid-run reset; queues track token order on both paths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tree_token_client;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       alloc_valid = 1'b0;
    logic       alloc_ready;
    logic [7:0] alloc_token;
    logic       release_valid = 1'b0;
    logic       release_ready;
    logic [7:0] release_token = 8'h00;
    logic [2:0] prefetch_count;
    logic       tree_mgt_req_valid;
    logic       tree_mgt_req_ready = 1'b0;
    logic [7:0] tree_mgt_req_addr = 8'h00;
    logic       tree_mgt_free_valid;
    logic       tree_mgt_free_ready = 1'b0;
    logic [7:0] tree_mgt_free_addr;
    logic       tree_mgt_full = 1'b0;

    tree_token_client #(
        .TOKEN_WIDTH    (8),
        .PREFETCH_DEPTH (4),
        .FREE_DEPTH     (4)
    ) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .alloc_valid         (alloc_valid),
        .alloc_ready         (alloc_ready),
        .alloc_token         (alloc_token),
        .release_valid       (release_valid),
        .release_ready       (release_ready),
        .release_token       (release_token),
        .prefetch_count      (prefetch_count),
        .tree_mgt_req_valid  (tree_mgt_req_valid),
        .tree_mgt_req_ready  (tree_mgt_req_ready),
        .tree_mgt_req_addr   (tree_mgt_req_addr),
        .tree_mgt_free_valid (tree_mgt_free_valid),
        .tree_mgt_free_ready (tree_mgt_free_ready),
        .tree_mgt_free_addr  (tree_mgt_free_addr),
        .tree_mgt_full       (tree_mgt_full)
    );

    always #5 aclk = ~aclk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] q_alloc[$];
    logic [7:0] q_free[$];
    logic [7:0] got_alloc[$];
    int         n_free = 0;
    bit         rel_hs = 1'b0;

    typedef struct {
        logic       rdy;
        logic       av;
        logic       mfull;
        logic       exp_rv;
        logic       exp_ar;
        logic [2:0] exp_cnt;
        logic [7:0] exp_tok;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: scoreboard handshakes at the falling edge, then advance past
    // the rising edge; the manager model offers its next address after a grant
    task automatic tick();
        bit         req_hs;
        logic [7:0] e;
        req_hs = 1'b0;
        rel_hs = 1'b0;
        @(negedge aclk);
        if (aresetn) begin
            if (alloc_valid && alloc_ready) begin
                got_alloc.push_back(alloc_token);
                if (q_alloc.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL alloc_unexpected actual=%0h required=none", alloc_token);
                end else begin
                    e = q_alloc.pop_front();
                    chk("alloc_order", alloc_token, e);
                end
            end
            if (tree_mgt_req_valid && tree_mgt_req_ready) begin
                q_alloc.push_back(tree_mgt_req_addr);
                req_hs = 1'b1;
            end
            if (tree_mgt_free_valid && tree_mgt_free_ready) begin
                n_free++;
                if (q_free.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL free_unexpected actual=%0h required=none", tree_mgt_free_addr);
                end else begin
                    e = q_free.pop_front();
                    chk("free_order", tree_mgt_free_addr, e);
                end
            end
            if (release_valid && release_ready) begin
                q_free.push_back(release_token);
                rel_hs = 1'b1;
            end
        end
        @(posedge aclk);
        #1;
        if (req_hs) tree_mgt_req_addr = tree_mgt_req_addr + 8'd1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alloc_ready"}, alloc_ready, 0);
        chk({tag, "_alloc_token"}, alloc_token, 0);
        chk({tag, "_count"}, prefetch_count, 0);
        chk({tag, "_req_valid"}, tree_mgt_req_valid, 0);
        chk({tag, "_release_ready"}, release_ready, 0);
        chk({tag, "_free_valid"}, tree_mgt_free_valid, 0);
        chk({tag, "_free_addr"}, tree_mgt_free_addr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //              rdy   av    full  rv    ar    cnt   tok
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 8'h00};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'h01};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 8'h01};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 8'h01};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 8'h01};

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");

        // Fill from address 0 and refill after one alloc
        aresetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tree_mgt_req_ready = vecs[i].rdy;
            alloc_valid        = vecs[i].av;
            tree_mgt_full      = vecs[i].mfull;
            tick();
            chk($sformatf("vec%0d_req_valid", i), tree_mgt_req_valid, vecs[i].exp_rv);
            chk($sformatf("vec%0d_alloc_ready", i), alloc_ready, vecs[i].exp_ar);
            chk($sformatf("vec%0d_count", i), prefetch_count, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_alloc_token", i), alloc_token, vecs[i].exp_tok);
            if (i == 0) chk("first_release_ready", release_ready, 1);
        end
        chk("refill_addr_next", tree_mgt_req_addr, 8'h05);

        // Manager goes full while a request is pending and not yet granted
        tree_mgt_req_ready = 1'b0;
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        chk("mf_after_pop_count", prefetch_count, 3);
        tick();
        chk("mf_req_rises", tree_mgt_req_valid, 1);
        tree_mgt_full = 1'b1;
        tick();
        chk("mf_req_held1", tree_mgt_req_valid, 1);
        tick();
        chk("mf_req_held2", tree_mgt_req_valid, 1);
        chk("mf_count_held", prefetch_count, 3);
        tree_mgt_req_addr  = 8'h07;
        tree_mgt_req_ready = 1'b1;
        alloc_valid        = 1'b1;
        tick();
        alloc_valid = 1'b0;
        chk("mf_grant_idle", tree_mgt_req_valid, 0);
        chk("mf_grant_count", prefetch_count, 3);
        tick();
        chk("mf_idle1", tree_mgt_req_valid, 0);
        tick();
        chk("mf_idle2", tree_mgt_req_valid, 0);
        tree_mgt_full = 1'b0;
        tick();
        chk("mf_clear_req", tree_mgt_req_valid, 1);
        tick();
        chk("mf_refill_count", prefetch_count, 4);
        chk("mf_refill_idle", tree_mgt_req_valid, 0);
        chk("mf_head", alloc_token, 8'h03);

        // Release buffering with manager backpressure
        tree_mgt_req_ready  = 1'b0;
        tree_mgt_free_ready = 1'b0;
        n_free = 0;
        for (int i = 0; i < 4; i++) begin
            release_valid = 1'b1;
            release_token = 8'h10 + 8'(i);
            tick();
            chk($sformatf("rel_accept%0d", i), rel_hs, 1);
        end
        chk("rel_full_ready", release_ready, 0);
        release_token = 8'h14;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rel_stall_ready", release_ready, 0);
            chk("rel_stall_accept", rel_hs, 0);
            chk("rel_stall_free_valid", tree_mgt_free_valid, 1);
            chk("rel_stall_free_addr", tree_mgt_free_addr, 8'h10);
        end
        tree_mgt_free_ready = 1'b1;
        for (int i = 0; i < 20 && n_free < 5; i++) begin
            tick();
            if (rel_hs) release_valid = 1'b0;
        end
        chk("rel_freed_total", n_free, 5);
        chk("rel_drained", tree_mgt_free_valid, 0);
        chk("rel_ready_again", release_ready, 1);

        // Build mid-run state: 3 prefetched, request pending, 2 releases queued
        tree_mgt_free_ready = 1'b0;
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        tick();
        chk("pre_rst_req_valid", tree_mgt_req_valid, 1);
        chk("pre_rst_count", prefetch_count, 3);
        release_valid = 1'b1;
        release_token = 8'h20;
        tick();
        release_token = 8'h21;
        tick();
        release_valid = 1'b0;
        chk("pre_rst_free_valid", tree_mgt_free_valid, 1);

        // Asynchronous reset mid-cycle
        #3;
        aresetn = 1'b0;
        #1;
        chk_all_zero("async_rst");
        q_alloc.delete();
        q_free.delete();
        tick();
        tick();
        chk("rst_hold_count", prefetch_count, 0);

        // Restart with new manager addresses and continuous alloc
        tree_mgt_req_addr   = 8'h40;
        tree_mgt_req_ready  = 1'b1;
        tree_mgt_free_ready = 1'b1;
        alloc_valid         = 1'b1;
        got_alloc.delete();
        aresetn = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i >= 1) chk($sformatf("stream_ready%0d", i), alloc_ready, 1);
        end
        alloc_valid = 1'b0;
        chk("stream_len", got_alloc.size(), 12);
        for (int i = 0; i < 12 && i < got_alloc.size(); i++) begin
            chk($sformatf("stream_tok%0d", i), got_alloc[i], 8'h40 + 8'(i));
        end
        chk("stream_no_stale_free", tree_mgt_free_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
